fir_filter_mc: RTL and testbench



---
 rtl/fir_filter_mc.sv | 161 ++++++++++++++++
 tb/tb_fir_filter_mc.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_mc.sv
// Multi-channel time-multiplexed signed FIR; one shared MAC walks Order+1 taps per sample.
// Latency: result valid Order+2 cycles after input accept; one sample per Order+3 cycles.
// Backpressure: input ready only in IDLE; result and channel held until data_out_ready_i.
// Ports: clk_i/rst_ni (async active-low); coef_we_i/coef_addr_i/coef_data_i coefficient load;
//        data_in_valid_i/data_in_ready_o/data_in_ch_i/data_in_i sample input;
//        data_out_valid_o/data_out_ready_i/data_out_ch_o/data_out_o result; busy_o when not IDLE.
// Build option: define FIR_SATURATE_EN to clamp the result to DataWidth, otherwise it wraps.
module fir_filter_mc #(
    parameter int Order       = 15,
    parameter int DataWidth   = 16,
    parameter int CoeffWidth  = 16,
    parameter int FracBits    = 15,
    parameter int NumChannels = 2,
    parameter int AddrWidth   = $clog2(Order + 1),
    parameter int ChWidth     = (NumChannels > 1) ? $clog2(NumChannels) : 1,
    parameter int AccWidth    = DataWidth + CoeffWidth + AddrWidth
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        coef_we_i,
    input  logic [AddrWidth-1:0]        coef_addr_i,
    input  logic signed [CoeffWidth-1:0] coef_data_i,
    input  logic                        data_in_valid_i,
    output logic                        data_in_ready_o,
    input  logic [ChWidth-1:0]          data_in_ch_i,
    input  logic signed [DataWidth-1:0] data_in_i,
    output logic                        data_out_valid_o,
    input  logic                        data_out_ready_i,
    output logic [ChWidth-1:0]          data_out_ch_o,
    output logic signed [DataWidth-1:0] data_out_o,
    output logic                        busy_o
);

    localparam int ProdWidth = DataWidth + CoeffWidth;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

    state_e                       state_q, state_d;
    logic [AddrWidth-1:0]         k_q, k_d;
    logic signed [AccWidth-1:0]   acc_q, acc_d;
    logic [ChWidth-1:0]           ch_q, ch_d;

    logic signed [DataWidth-1:0]  x_q    [NumChannels][Order+1];
    logic signed [CoeffWidth-1:0] coef_q [Order+1];

    logic                         in_hs;
    logic                         ch_ok;
    logic                         coef_wr;
    logic signed [ProdWidth-1:0]  prod;

    assign in_hs   = data_in_valid_i && data_in_ready_o;
    assign ch_ok   = int'(data_in_ch_i) < NumChannels;
    // Coefficients only change between samples so a running MAC sees a consistent set.
    assign coef_wr = coef_we_i && (state_q == IDLE) && (int'(coef_addr_i) <= Order);
    assign prod    = coef_q[k_q] * x_q[ch_q][k_q];

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        ch_d    = ch_q;
        case (state_q)
            IDLE: begin
                // An out-of-range channel is accepted and dropped without leaving IDLE.
                if (in_hs && ch_ok) begin
                    ch_d    = data_in_ch_i;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + {{(AccWidth-ProdWidth){prod[ProdWidth-1]}}, prod};
                if (k_q == AddrWidth'(Order)) begin
                    state_d = OUT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            OUT: begin
                if (data_out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            ch_q    <= ch_d;
        end
    end

    // Per-channel delay lines: newest sample at position 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NumChannels; c++) begin
                for (int i = 0; i <= Order; i++) begin
                    x_q[c][i] <= '0;
                end
            end
        end else if (in_hs && ch_ok) begin
            for (int c = 0; c < NumChannels; c++) begin
                if (data_in_ch_i == ChWidth'(c)) begin
                    for (int i = Order; i > 0; i--) begin
                        x_q[c][i] <= x_q[c][i-1];
                    end
                    x_q[c][0] <= data_in_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i <= Order; i++) begin
                coef_q[i] <= '0;
            end
        end else if (coef_wr) begin
            coef_q[coef_addr_i] <= coef_data_i;
        end
    end

    assign data_in_ready_o  = (state_q == IDLE);
    assign data_out_valid_o = (state_q == OUT);
    assign busy_o           = (state_q != IDLE);
    assign data_out_ch_o    = ch_q;

`ifdef FIR_SATURATE_EN
    localparam logic signed [AccWidth-1:0] SatMax =
        {{(AccWidth-DataWidth+1){1'b0}}, {(DataWidth-1){1'b1}}};
    localparam logic signed [AccWidth-1:0] SatMin =
        {{(AccWidth-DataWidth+1){1'b1}}, {(DataWidth-1){1'b0}}};

    logic signed [AccWidth-1:0] acc_sh;
    assign acc_sh = acc_q >>> FracBits;

    always_comb begin
        if (acc_sh > SatMax) begin
            data_out_o = SatMax[DataWidth-1:0];
        end else if (acc_sh < SatMin) begin
            data_out_o = SatMin[DataWidth-1:0];
        end else begin
            data_out_o = acc_sh[DataWidth-1:0];
        end
    end
`else
    // Arithmetic shift floors toward -inf; the cast keeps the low DataWidth bits (wrap).
    assign data_out_o = DataWidth'(acc_q >>> FracBits);
`endif

endmodule

// File: tb/tb_fir_filter_mc.sv
module tb_fir_filter_mc;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               coef_we_i;
    logic [1:0]         coef_addr_i;
    logic signed [15:0] coef_data_i;
    logic               data_in_valid_i;
    logic               data_in_ready_o;
    logic [1:0]         data_in_ch_i;
    logic signed [15:0] data_in_i;
    logic               data_out_valid_o;
    logic               data_out_ready_i;
    logic [1:0]         data_out_ch_o;
    logic signed [15:0] data_out_o;
    logic               busy_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    fir_filter_mc #(
        .Order(3), .DataWidth(16), .CoeffWidth(16), .FracBits(0), .NumChannels(3)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i), .coef_data_i(coef_data_i),
        .data_in_valid_i(data_in_valid_i), .data_in_ready_o(data_in_ready_o),
        .data_in_ch_i(data_in_ch_i), .data_in_i(data_in_i),
        .data_out_valid_o(data_out_valid_o), .data_out_ready_i(data_out_ready_i),
        .data_out_ch_o(data_out_ch_o), .data_out_o(data_out_o), .busy_o(busy_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        coef_we_i = 1'b0; data_in_valid_i = 1'b0; data_out_ready_i = 1'b1;
        repeat (2) tick();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic wr_coef(input logic [1:0] a, input logic signed [15:0] d);
        coef_we_i = 1'b1; coef_addr_i = a; coef_data_i = d;
        tick();
        coef_we_i = 1'b0;
    endtask

    task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
        wr_coef(2'd0, 16'(c0)); wr_coef(2'd1, 16'(c1));
        wr_coef(2'd2, 16'(c2)); wr_coef(2'd3, 16'(c3));
    endtask

    // Sends one sample, waits (bounded) for the result, consumes it when ready is high.
    // lat counts cycles from the accept cycle to the first valid cycle; -1 on timeout.
    task automatic run_sample(input logic [1:0] ch, input logic signed [15:0] v,
                              output int lat, output logic signed [15:0] y,
                              output logic [1:0] och);
        int n;
        data_in_ch_i = ch; data_in_i = v; data_in_valid_i = 1'b1;
        n = 0;
        while (!data_in_ready_o && n < 50) begin tick(); n++; end
        tick();
        data_in_valid_i = 1'b0;
        lat = 1;
        while (!data_out_valid_o && lat < 50) begin tick(); lat++; end
        y = data_out_o; och = data_out_ch_o;
        if (!data_out_valid_o) lat = -1;
        if (data_out_valid_o && data_out_ready_i) tick();
    endtask

    task automatic test_reset();
        int lat; logic signed [15:0] y; logic [1:0] och;
        rst_ni = 1'b0;
        coef_we_i = 1'b0; coef_addr_i = '0; coef_data_i = '0;
        data_in_valid_i = 1'b0; data_in_ch_i = '0; data_in_i = '0; data_out_ready_i = 1'b1;
        repeat (2) tick();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        checks++; if (data_in_ready_o !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", data_in_ready_o); end
        checks++; if (data_out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", data_out_valid_o); end
        checks++; if (data_out_o !== 16'sd0) begin failures++; $display("FAIL rst_out got=%0d exp=0", data_out_o); end
        checks++; if (data_out_ch_o !== 2'd0) begin failures++; $display("FAIL rst_out_ch got=%0d exp=0", data_out_ch_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
        // Coefficients clear on reset: any sample gives zero.
        run_sample(2'd0, 16'sd5, lat, y, och);
        checks++; if (y !== 16'sd0 || lat != 5) begin failures++; $display("FAIL rst_coef_zero got=%0d lat=%0d exp=0 lat=5", y, lat); end
    endtask

    task automatic test_moving_sum();
        int lat; logic signed [15:0] y; logic [1:0] och;
        int inp[4]; int exp_y[4];
        inp = '{1, 2, 3, 4}; exp_y = '{1, 3, 6, 10};
        do_reset();
        set_coefs(1, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            run_sample(2'd0, 16'(inp[i]), lat, y, och);
            checks++; if (y !== 16'(exp_y[i])) begin failures++; $display("FAIL sum_out%0d got=%0d exp=%0d", i, y, exp_y[i]); end
            checks++; if (lat != 5) begin failures++; $display("FAIL sum_lat%0d got=%0d exp=5", i, lat); end
            checks++; if (och !== 2'd0) begin failures++; $display("FAIL sum_ch%0d got=%0d exp=0", i, och); end
        end
    endtask

    task automatic test_impulse();
        int lat; logic signed [15:0] y; logic [1:0] och;
        int inp[4]; int exp_y[4];
        inp = '{1, 0, 0, 0}; exp_y = '{5, -3, 2, 7};
        do_reset();
        set_coefs(5, -3, 2, 7);
        for (int i = 0; i < 4; i++) begin
            run_sample(2'd0, 16'(inp[i]), lat, y, och);
            checks++; if (y !== 16'(exp_y[i]) || lat != 5) begin failures++; $display("FAIL imp_out%0d got=%0d lat=%0d exp=%0d lat=5", i, y, lat, exp_y[i]); end
        end
    endtask

    task automatic test_channels();
        int lat; logic signed [15:0] y; logic [1:0] och;
        int inp[4]; int chs[4]; int exp_y[4];
        inp = '{10, 100, 20, 200}; chs = '{0, 1, 0, 1}; exp_y = '{10, 100, 30, 300};
        do_reset();
        set_coefs(1, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            run_sample(2'(chs[i]), 16'(inp[i]), lat, y, och);
            checks++; if (y !== 16'(exp_y[i])) begin failures++; $display("FAIL chan_out%0d got=%0d exp=%0d", i, y, exp_y[i]); end
            checks++; if (och !== 2'(chs[i])) begin failures++; $display("FAIL chan_ch%0d got=%0d exp=%0d", i, och, chs[i]); end
        end
    endtask

    task automatic test_bad_channel();
        int lat; logic signed [15:0] y; logic [1:0] och;
        bit seen;
        do_reset();
        set_coefs(1, 1, 1, 1);
        data_in_ch_i = 2'd3; data_in_i = 16'sd99; data_in_valid_i = 1'b1;
        tick();
        data_in_valid_i = 1'b0;
        checks++; if (busy_o !== 1'b0 || data_in_ready_o !== 1'b1) begin failures++; $display("FAIL badch_idle got busy=%b rdy=%b exp busy=0 rdy=1", busy_o, data_in_ready_o); end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (data_out_valid_o) seen = 1'b1;
            tick();
        end
        checks++; if (seen) begin failures++; $display("FAIL badch_no_out got=1 exp=0"); end
        run_sample(2'd0, 16'sd1, lat, y, och);
        checks++; if (y !== 16'sd1) begin failures++; $display("FAIL badch_iso got=%0d exp=1", y); end
    endtask

    task automatic test_saturate();
        int lat; logic signed [15:0] y; logic [1:0] och;
        logic signed [15:0] exp_v;
`ifdef FIR_SATURATE_EN
        exp_v = 16'sd32767;
`else
        exp_v = 16'sh0001;
`endif
        do_reset();
        set_coefs(32767, 32767, 32767, 32767);
        run_sample(2'd0, 16'sd32767, lat, y, och);
        checks++; if (y !== exp_v) begin failures++; $display("FAIL sat_out got=%0d exp=%0d", y, exp_v); end
    endtask

    task automatic test_coef_timing();
        int n;
        do_reset();
        // Write coef0=4 in the same cycle the sample 6 is accepted; a write during MAC is dropped.
        data_in_ch_i = 2'd0; data_in_i = 16'sd6; data_in_valid_i = 1'b1;
        coef_we_i = 1'b1; coef_addr_i = 2'd0; coef_data_i = 16'sd4;
        tick();
        data_in_valid_i = 1'b0;
        coef_addr_i = 2'd1; coef_data_i = 16'sd100;
        tick();
        coef_we_i = 1'b0;
        n = 0;
        while (!data_out_valid_o && n < 50) begin tick(); n++; end
        checks++; if (data_out_o !== 16'sd24 || !data_out_valid_o) begin failures++; $display("FAIL coef_same_cycle got=%0d exp=24", data_out_o); end
        tick();
        data_in_i = 16'sd1; data_in_valid_i = 1'b1;
        tick();
        data_in_valid_i = 1'b0;
        n = 0;
        while (!data_out_valid_o && n < 50) begin tick(); n++; end
        checks++; if (data_out_o !== 16'sd4 || !data_out_valid_o) begin failures++; $display("FAIL coef_busy_write got=%0d exp=4", data_out_o); end
        tick();
    endtask

    task automatic test_hold();
        int n;
        do_reset();
        set_coefs(1, 1, 1, 1);
        data_out_ready_i = 1'b0;
        data_in_ch_i = 2'd0; data_in_i = 16'sd3; data_in_valid_i = 1'b1;
        tick();
        // Keep offering the next sample while the block is busy.
        data_in_i = 16'sd50;
        n = 1;
        while (!data_out_valid_o && n < 50) begin tick(); n++; end
        checks++; if (n != 5) begin failures++; $display("FAIL hold_lat got=%0d exp=5", n); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (data_out_o !== 16'sd3 || data_out_ch_o !== 2'd0 || data_out_valid_o !== 1'b1 || data_in_ready_o !== 1'b0 || busy_o !== 1'b1) begin
                failures++;
                $display("FAIL hold_stable%0d got out=%0d ch=%0d vld=%b rdy=%b busy=%b exp out=3 ch=0 vld=1 rdy=0 busy=1",
                         i, data_out_o, data_out_ch_o, data_out_valid_o, data_in_ready_o, busy_o);
            end
            coef_we_i = (i == 3); coef_addr_i = 2'd0; coef_data_i = 16'sd9;
            tick();
        end
        coef_we_i = 1'b0;
        data_out_ready_i = 1'b1;
        tick();
        checks++; if (data_out_valid_o !== 1'b0 || data_in_ready_o !== 1'b1) begin failures++; $display("FAIL hold_release got vld=%b rdy=%b exp vld=0 rdy=1", data_out_valid_o, data_in_ready_o); end
        tick();
        data_in_valid_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL hold_accept got busy=%b exp=1", busy_o); end
        n = 0;
        while (!data_out_valid_o && n < 50) begin tick(); n++; end
        checks++; if (data_out_o !== 16'sd53 || !data_out_valid_o) begin failures++; $display("FAIL hold_next got=%0d exp=53", data_out_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat; logic signed [15:0] y; logic [1:0] och;
        do_reset();
        set_coefs(1, 1, 1, 1);
        data_in_ch_i = 2'd0; data_in_i = 16'sd5; data_in_valid_i = 1'b1;
        tick();
        data_in_valid_i = 1'b0;
        tick();
        rst_ni = 1'b0;
        #1;
        checks++;
        if (data_out_o !== 16'sd0 || data_out_valid_o !== 1'b0 || busy_o !== 1'b0 || data_out_ch_o !== 2'd0 || data_in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL mid_rst got out=%0d vld=%b busy=%b ch=%0d rdy=%b exp 0 0 0 0 1",
                     data_out_o, data_out_valid_o, busy_o, data_out_ch_o, data_in_ready_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        set_coefs(1, 1, 1, 1);
        run_sample(2'd0, 16'sd7, lat, y, och);
        checks++; if (y !== 16'sd7 || lat != 5) begin failures++; $display("FAIL mid_rst_hist got=%0d lat=%0d exp=7 lat=5", y, lat); end
    endtask

    initial begin
        test_reset();
        test_moving_sum();
        test_impulse();
        test_channels();
        test_bad_channel();
        test_saturate();
        test_coef_timing();
        test_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
